// File: rtl/alu_seq_pkg.sv
// Shared opcode constants and FSM state encoding for the sequential ALU stage.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_EXEC   = 3'd3,
        S_WRITE  = 3'd4
    } state_t;

endpackage

// File: rtl/alu_mul_shiftadd.sv
// Shift-add multiplier: one partial product per cycle, WIDTH cycles after start.
// product is the running sum including the current step, so it is final while done is high.
module alu_mul_shiftadd #(
    parameter int WIDTH = 16
) (
    input  logic               CLK,
    input  logic               CLR,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               done
);

    localparam int CW = $clog2(WIDTH);

    logic              run;
    logic [CW-1:0]     cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] pp;

    // a and b are held stable by the caller for the whole run
    always_comb begin
        pp      = b[cnt] ? ({{WIDTH{1'b0}}, a} << cnt) : '0;
        product = acc + pp;
        done    = run && (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            run <= 1'b0;
            cnt <= '0;
            acc <= '0;
        end else if (start) begin
            run <= 1'b1;
            cnt <= '0;
            acc <= '0;
        end else if (run) begin
            acc <= product;
            cnt <= cnt + 1'b1;
            if (done)
                run <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq_stage.sv
// Sequential ALU stage: loads A then B from the shared bus, executes, and writes
// the result to the destination register with an active-low strobe.
module alu_seq_stage
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             START,
    input  logic [2:0]       OP,
    input  logic [WIDTH-1:0] BUS,
    output logic             EA_A,
    output logic             EA_B,
    output logic [WIDTH-1:0] D_OUT,
    output logic             R_W_OUT,
    output logic             BUSY,
    output logic             DONE,
    output logic             FLAG_Z,
    output logic             FLAG_C,
    output logic             FLAG_N
);

    state_t             state, state_nx;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q, res;
    logic               res_c;
    logic [WIDTH:0]     sum;
    logic               is_sub;
    logic [2*WIDTH-1:0] mul_prod;
    logic               mul_done;

    alu_mul_shiftadd #(.WIDTH(WIDTH)) u_mul (
        .CLK     (CLK),
        .CLR     (CLR),
        .start   (state == S_LOAD_B),
        .a       (a_q),
        .b       (b_q),
        .product (mul_prod),
        .done    (mul_done)
    );

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (START) state_nx = S_LOAD_A;
            S_LOAD_A: state_nx = S_LOAD_B;
            S_LOAD_B: state_nx = S_EXEC;
            S_EXEC:   if (op_q != OP_MUL || mul_done) state_nx = S_WRITE;
            S_WRITE:  state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // SUB reuses the adder as A + ~B + 1 so carry-out means "no borrow"
    always_comb begin
        is_sub = (op_q == OP_SUB);
        sum    = {1'b0, a_q} + {1'b0, (is_sub ? ~b_q : b_q)} + (WIDTH+1)'(is_sub);
        res    = '0;
        res_c  = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB: begin res = sum[WIDTH-1:0]; res_c = sum[WIDTH]; end
            OP_AND: res = a_q & b_q;
            OP_OR:  res = a_q | b_q;
            OP_XOR: res = a_q ^ b_q;
            OP_SHL: res = a_q << b_q[3:0];
            OP_SHR: res = a_q >> b_q[3:0];
            OP_MUL: begin
                res   = mul_prod[WIDTH-1:0];
                res_c = |mul_prod[2*WIDTH-1:WIDTH];
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            op_q   <= OP_ADD;
            a_q    <= '0;
            b_q    <= '0;
            D_OUT  <= '0;
            FLAG_Z <= 1'b0;
            FLAG_C <= 1'b0;
            FLAG_N <= 1'b0;
        end else begin
            if (state == S_IDLE && START) op_q <= OP;
            if (state == S_LOAD_A)        a_q  <= BUS;
            if (state == S_LOAD_B)        b_q  <= BUS;
            if (state == S_EXEC && state_nx == S_WRITE) begin
                D_OUT  <= res;
                FLAG_Z <= (res == '0);
                FLAG_C <= res_c;
                FLAG_N <= res[WIDTH-1];
            end
        end
    end

    assign EA_A    = (state == S_LOAD_A);
    assign EA_B    = (state == S_LOAD_B);
    assign R_W_OUT = (state != S_WRITE);
    assign BUSY    = (state != S_IDLE);
    assign DONE    = (state == S_WRITE);

endmodule

// File: doc/alu_seq_stage.md
ALU_SEQ_STAGE -- requirements
Module: alu_seq_stage

Interface
REQ-001 Parameter: WIDTH, 16, datapath width; only 16 is supported.
REQ-002 Reset CLR is asynchronous and active-low; clock is CLK.
REQ-003 CLK  input  1  rising-edge clock.
REQ-004 CLR  input  1  asynchronous active-low reset.
REQ-005 START  input  1  operation request, sampled only in IDLE.
REQ-006 OP  input  3  opcode, latched with START.
REQ-007 BUS  input  16  shared register read bus; the selected source register drives it through its Ea/Qa port.
REQ-008 EA_A  output  1  read enable for the operand-A source register.
REQ-009 EA_B  output  1  read enable for the operand-B source register.
REQ-010 D_OUT  output  16  result, wired to the destination register D.
REQ-011 R_W_OUT  output  1  destination write strobe, active-low (0 = write).
REQ-012 BUSY  output  1  high in every state except IDLE.
REQ-013 DONE  output  1  one-cycle pulse, asserted in the WRITE state.
REQ-014 FLAG_Z, FLAG_C, FLAG_N  output  1 each  result flags.

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD_A, LOAD_B, EXEC and WRITE; all control outputs SHALL be decoded from the registered state (Moore).
REQ-016 State transitions SHALL be:
- IDLE -> LOAD_A when START=1, latching OP at the same edge.
- LOAD_A -> LOAD_B unconditionally.
- LOAD_B -> EXEC unconditionally.
- EXEC -> WRITE after 1 cycle, or after 16 cycles for MUL.
- WRITE -> IDLE unconditionally.
REQ-017 EA_A SHALL be 1 only in LOAD_A, and BUS SHALL be captured into operand register A at the end of that cycle; EA_B/B SHALL behave the same in LOAD_B. EA_A and EA_B SHALL never be 1 together.
REQ-018 Opcodes SHALL be:
- 000 ADD: A+B, C = carry out.
- 001 SUB: A-B computed as A+~B+1, C = carry out (1 = no borrow).
- 010 AND, 011 OR, 100 XOR: C=0.
- 101 SHL: A<<B[3:0]; 110 SHR: logical A>>B[3:0]; C=0 for both.
- 111 MUL: low 16 bits of A*B, C=1 iff the upper 16 bits of the product are nonzero.
REQ-019 MUL SHALL be shift-add, one partial product per EXEC cycle, 16 EXEC cycles in total.
REQ-020 In WRITE, R_W_OUT SHALL be 0 for exactly one cycle and D_OUT SHALL hold the result.
REQ-021 D_OUT and the flags SHALL be updated on entry to WRITE and held unchanged until the next WRITE.
REQ-022 Flag definitions: FLAG_Z = (result==0); FLAG_N = result[15].
REQ-023 Latency: with START sampled at edge 0, WRITE is the 4th cycle after it (R_W_OUT low in cycle 4) for non-MUL ops, and the 19th cycle for MUL.
REQ-024 START while BUSY=1 SHALL be ignored; OP changes after acceptance SHALL have no effect.
REQ-025 START asserted during the WRITE cycle SHALL be ignored; START is accepted again from IDLE onward.
REQ-026 R_W_OUT SHALL be 1 in every state other than WRITE.

Reset
REQ-027 While CLR=0:
- state = IDLE.
- A, B, D_OUT = 0; FLAG_Z/C/N = 0.
- R_W_OUT = 1.
- EA_A, EA_B, BUSY, DONE = 0.
REQ-028 CLR asserted mid-operation SHALL abort immediately with no write strobe; after CLR release the block SHALL wait in IDLE for a new START.

Structure
REQ-029 Package alu_seq_pkg SHALL hold the opcode constants (OP_ADD..OP_MUL) and the state encoding type.
REQ-030 The MUL datapath SHALL be a sub-module, alu_mul_shiftadd (inputs start/A/B; outputs 32-bit product and done after 16 cycles), instantiated once.

Verification
REQ-031 ADD, BUS=0x7FFF in LOAD_A and 0x0001 in LOAD_B -> D_OUT=0x8000, N=1, Z=0, C=0; R_W_OUT=0 in the 4th cycle after START; DONE pulses once.
REQ-032 SUB 0x0005-0x0005 -> D_OUT=0x0000, Z=1, C=1; SUB 0x0003-0x0005 -> D_OUT=0xFFFE, N=1, C=0.
REQ-033 MUL 0x0123*0x0010 -> D_OUT=0x1230, C=0, R_W_OUT low in the 19th cycle; MUL 0x1000*0x0010 -> D_OUT=0x0000, Z=1, C=1.
REQ-034 SHL 0x0001 by B=0x0013 -> shift by 3 -> D_OUT=0x0008; SHR 0x8000 by 0x000F -> D_OUT=0x0001.
REQ-035 START pulsed again during LOAD_B, and again during WRITE -> exactly one write strobe occurs and BUSY=0 afterwards; OP changed mid-operation -> result follows the latched OP.
REQ-036 CLR=0 during the 8th MUL EXEC cycle -> all outputs immediately at reset values, no R_W_OUT=0 pulse, block idle after release until the next START.
